// File: rtl/bk_test_sched.sv
// bk_test_sched: one time-shared breakdown self-test controller for all channels.
// Each enabled channel gets one slot: pulse, response window, then idle gap.
module bk_test_sched #(
   parameter int CH_NUM  = 4,
   parameter int PERIOD  = 500000,
   parameter int PULSE_W = 875,
   parameter int WIN     = 2500,
   localparam int CW     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
   localparam int NW     = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
   input  logic              i_clk_25m,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [CH_NUM-1:0] i_ch_en,
   input  logic [CH_NUM-1:0] i_bk_fb,
   output logic [CH_NUM-1:0] o_bk_pulse,
   output logic [CW-1:0]     o_cur_ch,
   output logic              o_busy,
   output logic              o_done,
   output logic [CH_NUM-1:0] o_fail
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEL,
      S_PULSE,
      S_WAIT,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [NW-1:0] C_PEND = NW'(PULSE_W - 1);
   localparam logic [NW-1:0] C_WEND = NW'(PULSE_W + WIN - 1);
   localparam logic [NW-1:0] C_SEND = NW'(PERIOD - 1);
   localparam logic [CW-1:0] LAST   = CW'(CH_NUM - 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     ch_q, ch_d;
   logic [CW-1:0]     cur_q, cur_d;
   logic [NW-1:0]     cnt_q, cnt_d;
   logic [CH_NUM-1:0] en_q, en_d;
   logic [CH_NUM-1:0] fail_q, fail_d;
   logic              hit_q, hit_d;
   logic [CH_NUM-1:0] fb_s1, fb_s2;

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      cur_d   = cur_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      fail_d  = fail_q;
      hit_d   = hit_q;
      unique case (state_q)
         S_IDLE: begin
            if (i_start) begin
               en_d    = i_ch_en;
               fail_d  = fail_q & i_ch_en;
               hit_d   = 1'b0;
               ch_d    = '0;
               state_d = S_SEL;
            end
         end
         S_SEL: begin
            if (en_q[ch_q]) begin
               cnt_d   = '0;
               cur_d   = ch_q;
               hit_d   = 1'b0;
               state_d = S_PULSE;
            end else if (ch_q == LAST) begin
               state_d = S_DONE;
            end else begin
               ch_d = ch_q + 1'b1;
            end
         end
         S_PULSE: begin
            cnt_d = cnt_q + 1'b1;
            hit_d = hit_q | fb_s2[ch_q];
            if (cnt_q == C_PEND) state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            hit_d = hit_q | fb_s2[ch_q];
            if (cnt_q == C_WEND) state_d = S_GAP;
         end
         S_GAP: begin
            if (cnt_q == C_SEND) begin
               fail_d[ch_q] = ~hit_q;
               if (ch_q == LAST) begin
                  state_d = S_DONE;
               end else begin
                  ch_d    = ch_q + 1'b1;
                  state_d = S_SEL;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk_25m) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         ch_q    <= '0;
         cur_q   <= '0;
         cnt_q   <= '0;
         en_q    <= '0;
         fail_q  <= '0;
         hit_q   <= 1'b0;
         fb_s1   <= '0;
         fb_s2   <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         fail_q  <= fail_d;
         hit_q   <= hit_d;
         fb_s1   <= i_bk_fb;
         fb_s2   <= fb_s1;
      end
   end

   // Outputs decode straight from state so reset clears them on the next edge.
   always_comb begin
      o_bk_pulse = '0;
      if (state_q == S_PULSE) o_bk_pulse = CH_NUM'(1) << ch_q;
   end

   assign o_busy   = (state_q != S_IDLE) && (state_q != S_DONE);
   assign o_done   = (state_q == S_DONE);
   assign o_cur_ch = cur_q;
   assign o_fail   = fail_q;

endmodule

// File: tb/tb_bk_test_sched.sv
// tb_bk_test_sched: directed and randomized scans of bk_test_sched
// against a slot-timing and feedback-window model.
module tb_bk_test_sched;

   localparam int CH  = 4;
   localparam int PER = 100;
   localparam int PW  = 10;
   localparam int WN  = 20;

   localparam int M_MIR  = 0;
   localparam int M_NONE = 1;
   localparam int M_DLY  = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CH-1:0] ch_en;
   logic [CH-1:0] bk_fb = '0;
   logic [CH-1:0] bk_pulse;
   logic [1:0]    cur_ch;
   logic          busy;
   logic          done;
   logic [CH-1:0] fail;

   always #20 clk = ~clk;

   bk_test_sched #(
      .CH_NUM (CH),
      .PERIOD (PER),
      .PULSE_W(PW),
      .WIN    (WN)
   ) dut (
      .i_clk_25m (clk),
      .i_rst     (rst),
      .i_start   (start),
      .i_ch_en   (ch_en),
      .i_bk_fb   (bk_fb),
      .o_bk_pulse(bk_pulse),
      .o_cur_ch  (cur_ch),
      .o_busy    (busy),
      .o_done    (done),
      .o_fail    (fail)
   );

   int compared   = 0;
   int mismatched = 0;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Feedback behaviour per channel, set by the stimulus between scans.
   int mode[CH] = '{default: M_MIR};
   int dly[CH]  = '{default: 0};

   // Monitor: samples each cycle mid-period and drives feedback.
   int            cyc = 0;
   logic [CH-1:0] prev_p = '0;
   int            fall_c[CH] = '{default: 0};
   bit            armed[CH] = '{default: 1'b0};
   int            pcnt[CH] = '{default: 0};
   int            last_rise[CH] = '{default: -1};
   int            done_cnt = 0;
   int            done_cyc = -1;
   int            busy_cnt = 0;
   int            multi_cnt = 0;

   always @(negedge clk) begin
      logic [CH-1:0] fb;
      fb = '0;
      for (int c = 0; c < CH; c++) begin
         if (bk_pulse[c] && !prev_p[c]) begin
            armed[c]     = 1'b0;
            last_rise[c] = cyc;
         end
         if (!bk_pulse[c] && prev_p[c]) begin
            armed[c]  = 1'b1;
            fall_c[c] = cyc;
         end
         if (bk_pulse[c]) pcnt[c]++;
         if (mode[c] == M_MIR) begin
            fb[c] = bk_pulse[c];
         end else if (mode[c] == M_DLY && armed[c]) begin
            fb[c] = (cyc - fall_c[c] >= dly[c]) &&
                    (cyc - fall_c[c] <= dly[c] + 2);
         end
      end
      if ($countones(bk_pulse) > 1) multi_cnt++;
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (busy === 1'b1) busy_cnt++;
      prev_p = bk_pulse;
      bk_fb  = fb;
      cyc++;
   end

   // Feedback driven d cycles after the pulse falls is seen 2 cycles later,
   // i.e. PW+d+2 cycles into the slot; the window closes at PW+WN-1.
   function automatic bit hits(input int c);
      if (mode[c] == M_MIR) return 1'b1;
      if (mode[c] == M_DLY) return (dly[c] + 2 <= WN - 1);
      return 1'b0;
   endfunction

   task automatic run_scan(input logic [CH-1:0] mask,
                           input bit disturb,
                           input string tag);
      int            s;
      int            acc;
      int            t_slots;
      int            budget;
      int            top;
      int            base_p[CH];
      int            base_done;
      int            base_busy;
      int            exp_rise[CH];
      logic [CH-1:0] exp_fail;

      @(posedge clk); #1;
      for (int c = 0; c < CH; c++) base_p[c] = pcnt[c];
      base_done = done_cnt;
      base_busy = busy_cnt;
      s         = cyc;
      ch_en     = mask;
      start     = 1'b1;

      acc      = s + 1;
      t_slots  = 0;
      exp_fail = '0;
      top      = -1;
      for (int c = 0; c < CH; c++) begin
         exp_rise[c] = acc + 1;
         acc        += mask[c] ? (PER + 1) : 1;
         t_slots    += mask[c] ? (PER + 1) : 1;
         exp_fail[c] = mask[c] && !hits(c);
         if (mask[c]) top = c;
      end

      @(posedge clk); #1;
      start  = 1'b0;
      budget = 0;
      while (done_cnt == base_done && budget < 2000) begin
         if (disturb) begin
            start = (budget % 29 == 7);
            ch_en = budget[3] ? ~mask : mask;
         end
         @(posedge clk); #1;
         budget++;
      end
      start = 1'b0;
      ch_en = mask;

      check({tag, "_done_seen"}, done_cnt - base_done, 1);
      check({tag, "_done_cyc"}, done_cyc, acc);
      check({tag, "_busy_cycles"}, busy_cnt - base_busy, t_slots);
      check({tag, "_busy_after"}, busy, 1'b0);
      check({tag, "_done_after"}, done, 1'b0);
      check({tag, "_fail"}, fail, exp_fail);
      check({tag, "_onehot"}, multi_cnt, 0);
      for (int c = 0; c < CH; c++) begin
         check($sformatf("%s_pw%0d", tag, c), pcnt[c] - base_p[c],
               mask[c] ? PW : 0);
         if (mask[c])
            check($sformatf("%s_rise%0d", tag, c), last_rise[c],
                  exp_rise[c]);
      end
      if (top >= 0) check({tag, "_cur_ch"}, cur_ch, top);
   endtask

   initial begin
      int budget;

      rst   = 1'b1;
      start = 1'b0;
      ch_en = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_pulse", bk_pulse, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_fail", fail, 0);
      check("rst_cur_ch", cur_ch, 0);

      // All mirror, all enabled.
      for (int c = 0; c < CH; c++) mode[c] = M_MIR;
      run_scan(4'b1111, 1'b0, "t1");

      // ch2 never answers.
      mode[2] = M_NONE;
      run_scan(4'b0101, 1'b0, "t2");

      // ch1 answers outside the window.
      mode[2] = M_MIR;
      mode[1] = M_DLY;
      dly[1]  = 25;
      run_scan(4'b1111, 1'b0, "t3a");

      // Reset in the 5th cycle of the ch0 pulse.
      for (int c = 0; c < CH; c++) mode[c] = M_MIR;
      @(posedge clk); #1;
      ch_en = 4'b1111;
      start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      budget = 0;
      while (!bk_pulse[0] && budget < 20) begin
         @(posedge clk); #1;
         budget++;
      end
      check("t5_pulse_seen", bk_pulse, 4'b0001);
      repeat (4) @(posedge clk);
      #1;
      check("t5_pre_rst", bk_pulse, 4'b0001);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("t5_pulse", bk_pulse, 0);
      check("t5_busy", busy, 0);
      check("t5_done", done, 0);
      check("t5_fail", fail, 0);
      check("t5_cur_ch", cur_ch, 0);
      run_scan(4'b1111, 1'b0, "t5_rerun");

      // ch1 answers inside the window.
      mode[1] = M_DLY;
      dly[1]  = 15;
      run_scan(4'b1111, 1'b0, "t3b");

      // Window edge: 17 still hits, 18 misses.
      dly[1] = 17;
      run_scan(4'b0010, 1'b0, "edge_in");
      dly[1] = 18;
      run_scan(4'b0010, 1'b0, "edge_out");

      // Nothing enabled; stale fail bits are cleared.
      run_scan(4'b0000, 1'b0, "t4");

      // Restart attempts and mask changes mid-scan.
      mode[1] = M_NONE;
      run_scan(4'b1010, 1'b1, "t6");

      for (int n = 0; n < 10; n++) begin
         for (int c = 0; c < CH; c++) begin
            mode[c] = $urandom_range(0, 2);
            dly[c]  = $urandom_range(0, 30);
         end
         run_scan(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  $sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
